// File: rtl/locked_reg_arbiter.sv
// Lock-protected configuration register with round-robin write arbitration.
// Writes are committed or rejected with one-cycle gnt/err pulses; rejections are counted.
module locked_reg_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int CW   = 8
) (
  input  logic             Clk,
  input  logic             resetn,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic             Lock,
  input  logic             scan_mode,
  input  logic             debug_unlocked,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  err,
  output logic [DW-1:0]    Data_out,
  output logic             lock_status,
  output logic [CW-1:0]    viol_cnt,
  output logic             busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, RELEASE} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_win;
  logic [DW-1:0]   r_data;
  logic [DW-1:0]   r_dout;
  logic            r_lock;
  logic [CW-1:0]   r_viol;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_err;

  logic [IW-1:0]   w_pick;
  logic            w_any;
  logic            w_eff_lock;
  logic            w_unused;

  // Scan and debug controls are deliberately kept out of every write decision.
  assign w_unused   = scan_mode ^ debug_unlocked;
  assign w_eff_lock = r_lock | Lock;

  // Round-robin search starting just above the last winner, wrapping around.
  always_comb begin
    int t;
    t      = 0;
    w_pick = '0;
    w_any  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      t = int'(r_rr_ptr) + k;
      if (t >= NREQ) t = t - NREQ;
      if (!w_any && req[IW'(t)]) begin
        w_pick = IW'(t);
        w_any  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_rr_ptr <= IW'(NREQ - 1);
      r_win    <= '0;
      r_data   <= '0;
      r_dout   <= '0;
      r_lock   <= 1'b0;
      r_viol   <= '0;
      r_gnt    <= '0;
      r_err    <= '0;
    end else begin
      r_gnt <= '0;
      r_err <= '0;
      if (Lock) r_lock <= 1'b1;
      case (r_state)
        IDLE: if (w_any) begin
          r_win    <= w_pick;
          r_rr_ptr <= w_pick;
          r_data   <= wdata[w_pick*DW +: DW];
          r_state  <= CHECK;
        end
        CHECK: begin
          if (w_eff_lock) begin
            r_err[r_win] <= 1'b1;
            if (r_viol != '1) r_viol <= r_viol + 1'b1;
          end else begin
            r_gnt[r_win] <= 1'b1;
            r_dout       <= r_data;
          end
          r_state <= RELEASE;
        end
        RELEASE: if (!req[r_win]) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign err         = r_err;
  assign Data_out    = r_dout;
  assign lock_status = r_lock;
  assign viol_cnt    = r_viol;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_locked_reg_arbiter.sv
// Directed self-checking bench for locked_reg_arbiter (NREQ=4, DW=16, CW=8).
module tb_locked_reg_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int CW   = 8;

  logic              Clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*DW-1:0] wdata = '0;
  logic              Lock = 1'b0;
  logic              scan_mode = 1'b0;
  logic              debug_unlocked = 1'b0;
  logic [NREQ-1:0]   gnt, err;
  logic [DW-1:0]     Data_out;
  logic              lock_status;
  logic [CW-1:0]     viol_cnt;
  logic              busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  locked_reg_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CW)) dut (
    .Clk(Clk), .resetn(resetn), .req(req), .wdata(wdata), .Lock(Lock),
    .scan_mode(scan_mode), .debug_unlocked(debug_unlocked),
    .gnt(gnt), .err(err), .Data_out(Data_out), .lock_status(lock_status),
    .viol_cnt(viol_cnt), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic apply_reset();
    resetn = 1'b0;
    req    = '0;
    Lock   = 1'b0;
    repeat (2) @(negedge Clk);
    resetn = 1'b1;
    @(negedge Clk);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 10; c++) begin
      if (!busy) break;
      @(negedge Clk);
    end
  endtask

  // Issue one write, capture the response pulse, then release the request.
  task automatic do_write(input int idx, input logic [DW-1:0] d,
                          output logic [NREQ-1:0] g, output logic [NREQ-1:0] e,
                          output bit tmo);
    wdata[idx*DW +: DW] = d;
    req[idx] = 1'b1;
    g = '0; e = '0; tmo = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      if ((gnt | err) != '0) begin
        g = gnt; e = err; tmo = 1'b0;
        break;
      end
    end
    req[idx] = 1'b0;
    @(negedge Clk);
    wait_idle();
  endtask

  task automatic test_reset();
    apply_reset();
    chk_cnt++; if (Data_out !== 16'h0) $display("FAIL reset_data got=%h exp=0", Data_out); else pass_cnt++;
    chk_cnt++; if (lock_status !== 1'b0) $display("FAIL reset_lock got=%b exp=0", lock_status); else pass_cnt++;
    chk_cnt++; if (viol_cnt !== 8'd0) $display("FAIL reset_viol got=%0d exp=0", viol_cnt); else pass_cnt++;
    chk_cnt++; if ({gnt, err, busy} !== 9'b0) $display("FAIL reset_pulses got=%b exp=0", {gnt, err, busy}); else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [NREQ-1:0] g, e; bit tmo;
    do_write(0, 16'hA5A5, g, e, tmo);
    chk_cnt++; if (tmo) $display("FAIL basic_timeout no response"); else pass_cnt++;
    chk_cnt++; if (g !== 4'b0001 || e !== 4'b0000) $display("FAIL basic_gnt got=%b/%b exp=0001/0000", g, e); else pass_cnt++;
    chk_cnt++; if (Data_out !== 16'hA5A5) $display("FAIL basic_data got=%h exp=a5a5", Data_out); else pass_cnt++;
    chk_cnt++; if (viol_cnt !== 8'd0) $display("FAIL basic_viol got=%0d exp=0", viol_cnt); else pass_cnt++;
    chk_cnt++; if (gnt !== 4'b0000) $display("FAIL basic_single_pulse got=%b exp=0000", gnt); else pass_cnt++;
  endtask

  task automatic test_latch();
    wdata[0 +: DW] = 16'h1111;
    req[0] = 1'b1;
    @(negedge Clk);
    chk_cnt++; if (busy !== 1'b1) $display("FAIL latch_busy got=%b exp=1", busy); else pass_cnt++;
    wdata[0 +: DW] = 16'h2222;
    @(negedge Clk);
    chk_cnt++; if (gnt !== 4'b0001) $display("FAIL latch_gnt got=%b exp=0001", gnt); else pass_cnt++;
    req[0] = 1'b0;
    @(negedge Clk);
    wait_idle();
    chk_cnt++; if (Data_out !== 16'h1111) $display("FAIL latch_data got=%h exp=1111", Data_out); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    bit seen;
    apply_reset();
    for (int i = 0; i < NREQ; i++) wdata[i*DW +: DW] = DW'(16'h1000 + i);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      logic [NREQ-1:0] exp_g;
      exp_g = '0;
      exp_g[exp_order[n]] = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge Clk);
        if ((gnt | err) != '0) begin seen = 1'b1; break; end
      end
      chk_cnt++;
      if (!seen || gnt !== exp_g || err !== 4'b0000)
        $display("FAIL rr_order[%0d] got=%b/%b exp=%b/0000", n, gnt, err, exp_g);
      else pass_cnt++;
      req[exp_order[n]] = 1'b0;
      @(negedge Clk);
      chk_cnt++;
      if (Data_out !== DW'(16'h1000 + exp_order[n]))
        $display("FAIL rr_data[%0d] got=%h exp=%h", n, Data_out, DW'(16'h1000 + exp_order[n]));
      else pass_cnt++;
      if (n == 3) begin
        wait_idle();
        req = 4'b1111;
      end
      if (n == 4) req = '0;
    end
    wait_idle();
  endtask

  task automatic test_lock();
    logic [NREQ-1:0] g, e; bit tmo;
    Lock = 1'b1;
    @(negedge Clk);
    Lock = 1'b0;
    @(negedge Clk);
    chk_cnt++; if (lock_status !== 1'b1) $display("FAIL lock_set got=%b exp=1", lock_status); else pass_cnt++;
    do_write(1, 16'h1234, g, e, tmo);
    chk_cnt++; if (tmo || e !== 4'b0010 || g !== 4'b0000) $display("FAIL lock_err got=%b/%b exp=0000/0010", g, e); else pass_cnt++;
    chk_cnt++; if (Data_out !== 16'h1000) $display("FAIL lock_data got=%h exp=1000", Data_out); else pass_cnt++;
    chk_cnt++; if (viol_cnt !== 8'd1) $display("FAIL lock_viol got=%0d exp=1", viol_cnt); else pass_cnt++;
    chk_cnt++; if (lock_status !== 1'b1) $display("FAIL lock_sticky got=%b exp=1", lock_status); else pass_cnt++;
  endtask

  task automatic test_scan_debug_saturate();
    logic [NREQ-1:0] g, e; bit tmo;
    bit any_gnt;
    scan_mode = 1'b1;
    debug_unlocked = 1'b1;
    do_write(2, 16'hFFFF, g, e, tmo);
    chk_cnt++; if (tmo || e !== 4'b0100 || g !== 4'b0000) $display("FAIL scan_err got=%b/%b exp=0000/0100", g, e); else pass_cnt++;
    chk_cnt++; if (Data_out !== 16'h1000) $display("FAIL scan_data got=%h exp=1000", Data_out); else pass_cnt++;
    chk_cnt++; if (viol_cnt !== 8'd2) $display("FAIL scan_viol got=%0d exp=2", viol_cnt); else pass_cnt++;
    any_gnt = 1'b0;
    for (int i = 0; i < 299; i++) begin
      do_write(i % NREQ, 16'hFFFF, g, e, tmo);
      if (tmo || g != '0) any_gnt = 1'b1;
      if (i == 252) begin
        chk_cnt++; if (viol_cnt !== 8'd255) $display("FAIL sat_reach got=%0d exp=255", viol_cnt); else pass_cnt++;
      end
    end
    chk_cnt++; if (any_gnt) $display("FAIL sat_no_gnt got=1 exp=0"); else pass_cnt++;
    chk_cnt++; if (viol_cnt !== 8'd255) $display("FAIL sat_hold got=%0d exp=255", viol_cnt); else pass_cnt++;
    chk_cnt++; if (Data_out !== 16'h1000) $display("FAIL sat_data got=%h exp=1000", Data_out); else pass_cnt++;
    scan_mode = 1'b0;
    debug_unlocked = 1'b0;
  endtask

  task automatic test_lock_in_check();
    logic [NREQ-1:0] g, e; bit tmo;
    apply_reset();
    do_write(0, 16'h5A5A, g, e, tmo);
    chk_cnt++; if (tmo || g !== 4'b0001) $display("FAIL lic_pre got=%b exp=0001", g); else pass_cnt++;
    wdata[0 +: DW] = 16'hBEEF;
    req[0] = 1'b1;
    @(negedge Clk);
    Lock = 1'b1;
    @(negedge Clk);
    Lock = 1'b0;
    chk_cnt++; if (err !== 4'b0001 || gnt !== 4'b0000) $display("FAIL lic_err got=%b/%b exp=0000/0001", gnt, err); else pass_cnt++;
    req[0] = 1'b0;
    @(negedge Clk);
    wait_idle();
    chk_cnt++; if (Data_out !== 16'h5A5A) $display("FAIL lic_data got=%h exp=5a5a", Data_out); else pass_cnt++;
    chk_cnt++; if (viol_cnt !== 8'd1 || lock_status !== 1'b1) $display("FAIL lic_state got=%0d/%b exp=1/1", viol_cnt, lock_status); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] g, e; bit tmo;
    bit pulsed;
    wdata[1*DW +: DW] = 16'h7777;
    req[1] = 1'b1;
    @(negedge Clk);
    resetn = 1'b0;
    #1;
    chk_cnt++;
    if ({gnt, err, busy, lock_status} !== 11'b0 || Data_out !== 16'h0 || viol_cnt !== 8'd0)
      $display("FAIL rst_mid_zero got=%b data=%h viol=%0d exp=0", {gnt, err, busy, lock_status}, Data_out, viol_cnt);
    else pass_cnt++;
    pulsed = 1'b0;
    repeat (2) begin
      @(negedge Clk);
      if ((gnt | err) != '0) pulsed = 1'b1;
    end
    chk_cnt++; if (pulsed) $display("FAIL rst_mid_pulse got=1 exp=0"); else pass_cnt++;
    req = '0;
    resetn = 1'b1;
    @(negedge Clk);
    do_write(2, 16'hC3C3, g, e, tmo);
    chk_cnt++; if (tmo || g !== 4'b0100 || e !== 4'b0000) $display("FAIL rst_mid_next got=%b/%b exp=0100/0000", g, e); else pass_cnt++;
    chk_cnt++; if (Data_out !== 16'hC3C3) $display("FAIL rst_mid_data got=%h exp=c3c3", Data_out); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latch();
    test_round_robin();
    test_lock();
    test_scan_debug_saturate();
    test_lock_in_check();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
